// File: rtl/video_fetch.sv
// Video fetch: issues 1/2/4 DRAM word requests per group, tracks tags, assembles a 32-bit shadow for the renderer.
// Optional late_cnt statistics output enabled by VIDEO_FETCH_STAT_EN.

module video_fetch_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so full only blocks an unpaired push.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
  end
endmodule

module video_fetch #(
  parameter int TAG_DEPTH = 4,
  parameter int ADDR_W    = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              line_start_s,
  input  logic              fetch_stb,
  input  logic [ADDR_W-1:0] video_addr,
  input  logic [4:0]        video_bw,
  input  logic [3:0]        fetch_sel,
  input  logic [1:0]        fetch_bsl,
  output logic              col_inc,
  output logic              dram_req,
  output logic [ADDR_W-1:0] dram_addr,
  input  logic              dram_next,
  input  logic              dram_strobe,
  input  logic [15:0]       dram_data,
  output logic [31:0]       fetch_data,
  output logic              late,
  output logic              underrun
`ifdef VIDEO_FETCH_STAT_EN
  ,
  output logic [7:0]        late_cnt
`endif
);
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  rem_q, rem_d, need;
  logic        fetch_en_q;
  logic [31:0] shadow_q, shadow_d, fetch_data_q;
  logic        late_q, late_d, underrun_q, underrun_d;
  logic        tag_full, tag_empty, accept, ret_vld, late_evt;
  logic [5:0]  tag_dout;
  logic [3:0]  ret_sel;
  logic [1:0]  ret_bsl;
  logic        unused_bw;

  // Cycles-of field is consumed by the renderer, not here.
  assign unused_bw = ^video_bw[4:3];

  always_comb begin
    need = 3'd1;
    case (video_bw[2:0])
      3'b010:  need = 3'd2;
      3'b100:  need = 3'd4;
      default: need = 3'd1;
    endcase
  end

  assign dram_req  = (state_q == ST_REQ) & ~tag_full;
  assign dram_addr = (state_q == ST_REQ) ? video_addr : '0;
  assign accept    = dram_req & dram_next;
  assign col_inc   = accept;
  assign ret_vld   = dram_strobe & ~tag_empty;
  assign late_evt  = fetch_stb & (state_q == ST_REQ);

  video_fetch_tag_fifo #(.DEPTH(TAG_DEPTH), .W(6)) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (dram_strobe),
    .din_i   ({fetch_sel, fetch_bsl}),
    .dout_o  (tag_dout),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign ret_sel = tag_dout[5:2];
  assign ret_bsl = tag_dout[1:0];

  always_comb begin
    shadow_d = shadow_q;
    if (ret_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (ret_sel[i]) begin
          case (ret_bsl)
            2'b00:   shadow_d[8*i +: 8] = dram_data[7:0];
            2'b11:   shadow_d[8*i +: 8] = dram_data[15:8];
            default: shadow_d[8*i +: 8] = (i % 2 == 1) ? dram_data[15:8] : dram_data[7:0];
          endcase
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (line_start_s) begin
      state_d = fetch_en ? ST_REQ : ST_IDLE;
      rem_d   = need;
    end else begin
      case (state_q)
        ST_IDLE: if (fetch_en && !fetch_en_q) begin
          state_d = ST_REQ;
          rem_d   = need;
        end
        ST_REQ: begin
          if (!fetch_en) begin
            state_d = ST_IDLE;
          end else if (fetch_stb) begin
            rem_d = need;
          end else if (accept) begin
            rem_d = rem_q - 3'd1;
            if (rem_q == 3'd1) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!fetch_en) begin
            state_d = ST_IDLE;
          end else if (fetch_stb) begin
            state_d = ST_REQ;
            rem_d   = need;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    late_d     = late_q;
    underrun_d = underrun_q;
    if (line_start_s) begin
      late_d     = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (late_evt)                  late_d     = 1'b1;
      if (dram_strobe && tag_empty)  underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      fetch_en_q   <= 1'b0;
      shadow_q     <= '0;
      fetch_data_q <= '0;
      late_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      fetch_en_q <= fetch_en;
      shadow_q   <= shadow_d;
      late_q     <= late_d;
      underrun_q <= underrun_d;
      if (fetch_stb) fetch_data_q <= shadow_d;
    end
  end

  assign fetch_data = fetch_data_q;
  assign late       = late_q;
  assign underrun   = underrun_q;

`ifdef VIDEO_FETCH_STAT_EN
  logic [7:0] late_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late_cnt_q <= '0;
    end else if (line_start_s) begin
      late_cnt_q <= '0;
    end else if (late_evt && late_cnt_q != 8'hFF) begin
      late_cnt_q <= late_cnt_q + 8'd1;
    end
  end

  assign late_cnt = late_cnt_q;
`endif
endmodule

// File: tb/tb_video_fetch.sv
// Scoreboard bench for video_fetch: expected fetch_data and request addresses are queued by stimulus, popped by a monitor.
module tb_video_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, line_start_s, fetch_stb;
  logic [20:0] video_addr;
  logic [4:0]  video_bw;
  logic [3:0]  fetch_sel;
  logic [1:0]  fetch_bsl;
  logic        col_inc, dram_req, dram_next, dram_strobe;
  logic [20:0] dram_addr;
  logic [15:0] dram_data;
  logic [31:0] fetch_data;
  logic        late, underrun;
`ifdef VIDEO_FETCH_STAT_EN
  logic [7:0]  late_cnt;
`endif

  video_fetch #(.TAG_DEPTH(4), .ADDR_W(21)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .line_start_s (line_start_s),
    .fetch_stb    (fetch_stb),
    .video_addr   (video_addr),
    .video_bw     (video_bw),
    .fetch_sel    (fetch_sel),
    .fetch_bsl    (fetch_bsl),
    .col_inc      (col_inc),
    .dram_req     (dram_req),
    .dram_addr    (dram_addr),
    .dram_next    (dram_next),
    .dram_strobe  (dram_strobe),
    .dram_data    (dram_data),
    .fetch_data   (fetch_data),
    .late         (late),
    .underrun     (underrun)
`ifdef VIDEO_FETCH_STAT_EN
    ,
    .late_cnt     (late_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          col_cnt = 0;
  int          base;
  logic        stb_pend = 1'b0;
  logic [31:0] exp_q [$];
  logic [20:0] col_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_stb(input logic [31:0] exp);
    exp_q.push_back(exp);
    fetch_stb = 1'b1;
    tick();
    fetch_stb = 1'b0;
  endtask

  // Monitor: fetch_data is checked the cycle after each strobe; each col_inc pops an expected address.
  always @(negedge clk) begin
    if (!rst_n) begin
      stb_pend = 1'b0;
    end else begin
      if (stb_pend) begin
        if (exp_q.size() == 0) check("fetch_data unexpected load", 32'd1, 32'd0);
        else check("fetch_data", fetch_data, exp_q.pop_front());
      end
      stb_pend = fetch_stb;
      if (col_inc) begin
        col_cnt++;
        if (col_q.size() == 0) check("col_inc unexpected", 32'd1, 32'd0);
        else check("dram_addr at col_inc", {11'd0, dram_addr}, {11'd0, col_q.pop_front()});
      end
    end
  end

  logic [3:0]  c_sel  [4] = '{4'b0011, 4'b1100, 4'b0001, 4'b0010};
  logic [1:0]  c_bsl  [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
  logic [15:0] c_data [4] = '{16'h1234, 16'h5678, 16'hAB00, 16'h00CD};
  logic [31:0] c_exp  [4] = '{32'h00001234, 32'h56781234, 32'h567812AB, 32'h567800AB};

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; line_start_s = 1'b0; fetch_stb = 1'b0;
    video_addr = '0; video_bw = '0; fetch_sel = '0; fetch_bsl = '0;
    dram_next = 1'b0; dram_strobe = 1'b0; dram_data = '0;
    repeat (2) tick();
    check("reset col_inc", {31'd0, col_inc}, 32'd0);
    check("reset dram_req", {31'd0, dram_req}, 32'd0);
    check("reset dram_addr", {11'd0, dram_addr}, 32'd0);
    check("reset fetch_data", fetch_data, 32'd0);
    check("reset late", {31'd0, late}, 32'd0);
    check("reset underrun", {31'd0, underrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Strobe with no tags outstanding: flagged, shadow untouched.
    fetch_sel = 4'hF; dram_data = 16'hFFFF; dram_strobe = 1'b1;
    tick();
    dram_strobe = 1'b0;
    check("underrun after empty strobe", {31'd0, underrun}, 32'd1);
    strobe_stb(32'h0);
    tick();
    line_start_s = 1'b1;
    tick();
    line_start_s = 1'b0;
    check("underrun cleared by line_start", {31'd0, underrun}, 32'd0);

    // One request per group, one col_inc per fetch strobe period.
    video_bw = 5'b01001; fetch_sel = 4'h0; dram_next = 1'b1;
    video_addr = 21'h01000; col_q.push_back(video_addr);
    base = col_cnt; fetch_en = 1'b1;
    repeat (4) tick();
    check("single-req first group", col_cnt - base, 1);
    for (int k = 1; k <= 3; k++) begin
      video_addr = 21'h01000 + 21'(k * 16);
      col_q.push_back(video_addr);
      dram_strobe = 1'b1;
      strobe_stb(32'h0);
      dram_strobe = 1'b0;
      repeat (3) tick();
      check("single-req group count", col_cnt - base, k + 1);
    end
    check("single-req late", {31'd0, late}, 32'd0);
    check("single-req underrun", {31'd0, underrun}, 32'd0);
    dram_strobe = 1'b1; dram_next = 1'b0;
    tick();
    dram_strobe = 1'b0; fetch_en = 1'b0;
    tick();

    // Four back-to-back requests with changing tags, then per-lane assembly with bypass.
    video_bw = 5'b11100; fetch_en = 1'b1;
    tick();
    check("four-req dram_req in REQ", {31'd0, dram_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      video_addr = 21'h02000 + 21'(i);
      fetch_sel = c_sel[i]; fetch_bsl = c_bsl[i];
      col_q.push_back(video_addr);
      dram_next = 1'b1;
      tick();
    end
    dram_next = 1'b0;
    check("four-req dram_req in WAIT", {31'd0, dram_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      dram_data = c_data[i]; dram_strobe = 1'b1;
      strobe_stb(c_exp[i]);
      dram_strobe = 1'b0;
      tick();
    end
    strobe_stb(32'h567800AB);
    tick();
    check("late after incomplete groups", {31'd0, late}, 32'd1);
`ifdef VIDEO_FETCH_STAT_EN
    check("late_cnt before clear", {24'd0, late_cnt}, 32'd4);
`endif
    line_start_s = 1'b1;
    tick();
    line_start_s = 1'b0;
    check("late cleared by line_start", {31'd0, late}, 32'd0);
`ifdef VIDEO_FETCH_STAT_EN
    check("late_cnt cleared", {24'd0, late_cnt}, 32'd0);
`endif

    // Fill the tag FIFO, then reload the group: requests must stall while full.
    fetch_sel = 4'h0; fetch_bsl = 2'b00; video_addr = 21'h03000;
    repeat (4) col_q.push_back(video_addr);
    base = col_cnt; dram_next = 1'b1;
    repeat (6) tick();
    check("fill accepts", col_cnt - base, 4);
    check("dram_req after fill", {31'd0, dram_req}, 32'd0);
    strobe_stb(32'h567800AB);
    repeat (4) tick();
    check("dram_req blocked when full", {31'd0, dram_req}, 32'd0);
    check("no 5th col_inc while full", col_cnt - base, 4);
    check("no late from WAIT", {31'd0, late}, 32'd0);
    col_q.push_back(video_addr);
    dram_strobe = 1'b1;
    tick();
    dram_strobe = 1'b0;
    tick();
    check("accept after pop", col_cnt - base, 5);
    check("dram_req full again", {31'd0, dram_req}, 32'd0);

    // Reset with two tags outstanding.
    dram_next = 1'b0; dram_strobe = 1'b1;
    repeat (2) tick();
    dram_strobe = 1'b0;
    check("dram_req with 2 tags", {31'd0, dram_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset col_inc", {31'd0, col_inc}, 32'd0);
    check("async reset dram_req", {31'd0, dram_req}, 32'd0);
    check("async reset dram_addr", {11'd0, dram_addr}, 32'd0);
    check("async reset fetch_data", fetch_data, 32'd0);
    check("async reset late", {31'd0, late}, 32'd0);
    check("async reset underrun", {31'd0, underrun}, 32'd0);
    fetch_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch_sel = 4'hF; dram_data = 16'hEEEE; dram_strobe = 1'b1;
    tick();
    dram_strobe = 1'b0;
    check("stray strobe after reset", {31'd0, underrun}, 32'd1);
    fetch_sel = 4'h0; video_bw = 5'b01001; video_addr = 21'h04000;
    col_q.push_back(video_addr);
    dram_next = 1'b1; base = col_cnt; fetch_en = 1'b1;
    repeat (4) tick();
    check("restart after reset", col_cnt - base, 1);

    // Strobe with one of four requests done: partial shadow, late set.
    dram_next = 1'b0; dram_strobe = 1'b1;
    tick();
    dram_strobe = 1'b0; video_bw = 5'b11100; line_start_s = 1'b1;
    tick();
    line_start_s = 1'b0;
    check("underrun cleared", {31'd0, underrun}, 32'd0);
    video_addr = 21'h05000; fetch_sel = 4'b0001; fetch_bsl = 2'b00;
    col_q.push_back(video_addr);
    dram_next = 1'b1;
    tick();
    dram_next = 1'b0; dram_data = 16'h0077; dram_strobe = 1'b1;
    tick();
    dram_strobe = 1'b0;
    strobe_stb(32'h00000077);
    tick();
    check("late on partial group", {31'd0, late}, 32'd1);
`ifdef VIDEO_FETCH_STAT_EN
    check("late_cnt partial", {24'd0, late_cnt}, 32'd1);
`endif
    fetch_en = 1'b0; line_start_s = 1'b1;
    tick();
    line_start_s = 1'b0;
    check("late cleared", {31'd0, late}, 32'd0);
    check("idle dram_req", {31'd0, dram_req}, 32'd0);
    repeat (2) tick();
    check("address queue drained", col_q.size(), 0);
    check("data queue drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
